// File: rtl/stage_if_if.sv
// Instruction-memory port of the fetch stage: one request channel and one
// response channel.
//
// Handshake: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both 1. Once imem_req_valid rises, it and imem_req_addr
// hold until that transfer. The one exception is a redirect, which may move
// the address on the following cycle. The response channel has no ready: the
// fetch stage takes imem_rsp_data on any edge where imem_rsp_valid is 1. The
// memory answers each accepted request exactly once, at least one cycle later.
interface stage_if_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
);
    logic                  imem_req_valid;
    logic [PC_WIDTH-1:0]   imem_req_addr;
    logic                  imem_req_ready;
    logic                  imem_rsp_valid;
    logic [INST_WIDTH-1:0] imem_rsp_data;

    // Fetch stage side
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    // Instruction memory side
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/stage_if.sv
// Instruction-fetch stage. It keeps a PC and issues at most one memory
// request at a time. It throws away responses that belong to a redirected
// path. It feeds the IF/ID pipeline register, and a one-entry hold buffer
// catches a response that lands while decode is stalled.
module stage_if #(
    parameter int                  PC_WIDTH       = 32,
    parameter int                  INST_WIDTH     = 32,
    parameter int                  REG_ADDR_WIDTH = 5,
    parameter logic [PC_WIDTH-1:0] RESET_PC       = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pc_sel,
    input  logic [PC_WIDTH-1:0]       pc_imm,
    input  logic                      stall,
    stage_if_if.master                imem,
    output logic [PC_WIDTH-1:0]       IF_ID_pc,
    output logic [INST_WIDTH-1:0]     IF_ID_inst,
    output logic                      IF_ID_valid,
    output logic [6:0]                IF_ID_inst_opcode,
    output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    output logic [REG_ADDR_WIDTH-1:0] IF_ID_rd,
    output logic [1:0]                o_state
);

    // FETCH: free to request. WAIT: one good request in flight.
    // DROP: the request in flight is wrong-path, so its response is discarded.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    // Bubble placed into IF/ID: addi x0, x0, 0
    localparam logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(32'h0000_0013);

    state_t                r_state;
    state_t                w_next_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_fetch_pc;
    logic                  r_hold_valid;
    logic [INST_WIDTH-1:0] r_hold_inst;
    logic [PC_WIDTH-1:0]   r_hold_pc;
    logic [PC_WIDTH-1:0]   r_ifid_pc;
    logic [INST_WIDTH-1:0] r_ifid_inst;
    logic                  r_ifid_valid;

    logic                  w_req_valid;
    logic                  w_accept;
    logic                  w_rsp_in_wait;
    logic [PC_WIDTH-1:0]   w_redirect_pc;

    // Requests are blocked while reset is high, so the first request shows
    // up in the first cycle after reset drops. They are also blocked while
    // the hold buffer owns an instruction that decode has not taken yet.
    assign w_req_valid   = (r_state == ST_FETCH) && !r_hold_valid && !reset;
    assign w_accept      = w_req_valid && imem.imem_req_ready;
    assign w_rsp_in_wait = (r_state == ST_WAIT) && imem.imem_rsp_valid;
    assign w_redirect_pc = pc_imm & ~PC_WIDTH'(3);

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = r_pc;

    assign IF_ID_pc          = r_ifid_pc;
    assign IF_ID_inst        = r_ifid_inst;
    assign IF_ID_valid       = r_ifid_valid;
    assign IF_ID_inst_opcode = r_ifid_inst[6:0];
    assign IF_ID_rd          = r_ifid_inst[7 +: REG_ADDR_WIDTH];
    assign IF_ID_rs1         = r_ifid_inst[15 +: REG_ADDR_WIDTH];
    assign IF_ID_rs2         = r_ifid_inst[20 +: REG_ADDR_WIDTH];
    assign o_state           = r_state;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: a redirect turns the request in flight into a wrong-path one
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (w_accept) begin
                    w_next_state = pc_sel ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    w_next_state = ST_FETCH;
                end else if (pc_sel) begin
                    w_next_state = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem.imem_rsp_valid) begin
                    w_next_state = ST_FETCH;
                end
            end
            default: w_next_state = ST_FETCH;
        endcase
    end

    // PC and fetch-address tracking; a redirect beats the increment
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            if (pc_sel) begin
                r_pc <= w_redirect_pc;
            end else if (w_accept) begin
                r_pc <= r_pc + PC_WIDTH'(4);
            end
            if (w_accept) begin
                r_fetch_pc <= r_pc;
            end
        end
    end

    // Hold buffer: keeps a good response that arrives during a stall
    always_ff @(posedge clk) begin
        if (reset || pc_sel) begin
            r_hold_valid <= 1'b0;
        end else if (r_hold_valid && !stall) begin
            r_hold_valid <= 1'b0;
        end else if (w_rsp_in_wait && stall) begin
            r_hold_valid <= 1'b1;
            r_hold_inst  <= imem.imem_rsp_data;
            r_hold_pc    <= r_fetch_pc;
        end
    end

    // IF/ID register. A stall freezes it. When not stalled it loads the held
    // or arriving instruction, and with nothing to deliver it drops valid so
    // decode does not run the same instruction twice.
    always_ff @(posedge clk) begin
        if (reset || pc_sel) begin
            r_ifid_pc    <= '0;
            r_ifid_inst  <= NOP_INST;
            r_ifid_valid <= 1'b0;
        end else if (!stall) begin
            if (r_hold_valid) begin
                r_ifid_pc    <= r_hold_pc;
                r_ifid_inst  <= r_hold_inst;
                r_ifid_valid <= 1'b1;
            end else if (w_rsp_in_wait) begin
                r_ifid_pc    <= r_fetch_pc;
                r_ifid_inst  <= imem.imem_rsp_data;
                r_ifid_valid <= 1'b1;
            end else begin
                r_ifid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/stage_if.md
STAGE_IF -- requirements
Module: stage_IF

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, meaning PC and address width.
REQ-002 SHALL have parameter INST_WIDTH, default 32, meaning instruction width.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 5, meaning register index width.
REQ-004 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-007 SHALL have port pc_sel, input, 1, branch/jump redirect from decode.
REQ-008 SHALL have port pc_imm, input, PC_WIDTH, redirect target.
REQ-009 SHALL have port stall, input, 1, hazard hold of the IF/ID register.
REQ-010 SHALL have ports imem_req_valid (output, 1), imem_req_addr (output, PC_WIDTH) and imem_req_ready (input, 1), the fetch request handshake.
REQ-011 SHALL have ports imem_rsp_valid (input, 1) and imem_rsp_data (input, INST_WIDTH), the fetch response.
REQ-012 SHALL have IF/ID outputs IF_ID_pc (PC_WIDTH), IF_ID_inst (INST_WIDTH), IF_ID_valid (1), IF_ID_inst_opcode (7), and IF_ID_rs1, IF_ID_rs2, IF_ID_rd (each REG_ADDR_WIDTH).

Function
REQ-013 SHALL hold a PC register; a request is accepted when imem_req_valid && imem_req_ready, and acceptance sets fetch_pc<=pc and pc<=pc+4 (wraps modulo 2^PC_WIDTH).
REQ-014 SHALL implement a 3-state FSM: FETCH (may request), WAIT (one request outstanding), DROP (outstanding response is wrong-path).
REQ-015 Transitions: FETCH->WAIT on accept; WAIT->FETCH on imem_rsp_valid; WAIT->DROP on pc_sel without rsp; FETCH->DROP on accept in the same cycle as pc_sel; DROP->FETCH on imem_rsp_valid.
REQ-016 imem_req_valid SHALL be 1 only in FETCH with the hold buffer empty; imem_req_addr SHALL equal pc.
REQ-017 Once imem_req_valid is asserted, it and the address SHALL stay stable until accepted, except that pc_sel may change the address in the following cycle.
REQ-018 At most one request SHALL be outstanding; a response arrives ≥1 cycle after acceptance, and the next request issues no earlier than the cycle after the response.
REQ-019 A response in WAIT with stall=0 SHALL load IF/ID at that edge: IF_ID_inst=imem_rsp_data, IF_ID_pc=fetch_pc, IF_ID_valid=1.
REQ-020 A response in WAIT with stall=1 SHALL be captured in a 1-entry hold buffer (inst, pc); the IF/ID register is unchanged.
REQ-021 When the hold buffer is full and stall=0, IF/ID SHALL load from the buffer and empty it; no request issues while it is full.
REQ-022 stall=1 without pc_sel SHALL freeze all IF_ID_* outputs.
REQ-023 pc_sel=1 SHALL, at that edge, set pc<=pc_imm with bits [1:0] forced to 0, and load a bubble into IF/ID (IF_ID_inst=32'h0000_0013, IF_ID_valid=0, IF_ID_pc=0), and clear the hold buffer.
REQ-024 pc_sel SHALL override stall and any same-cycle response or pc increment.
REQ-025 Responses in DROP SHALL be discarded; responses in FETCH (spurious) SHALL be ignored.
REQ-026 IF_ID_inst_opcode, IF_ID_rd, IF_ID_rs1 and IF_ID_rs2 SHALL be combinational slices of IF_ID_inst: [6:0], [11:7], [19:15] and [24:20] respectively.

Reset
REQ-027 reset=1 at a clock edge SHALL set pc=RESET_PC, FSM=FETCH, hold buffer empty, IF/ID to the bubble, and imem_req_valid=0 in the following cycle.
REQ-028 reset SHALL override pc_sel and stall; an in-flight response that arrives after reset SHALL be ignored (FETCH state).
REQ-029 The first request SHALL assert in the first cycle after reset deasserts.

Verification
REQ-030 Reset then ready=1 and 1-cycle response latency -> requests to 0x0, 0x4 and 0x8 on alternate cycles; IF_ID_pc sequence 0x0, 0x4, 0x8 with IF_ID_valid=1.
REQ-031 imem_req_ready held 0 for 3 cycles -> imem_req_valid=1 with address 0x0 stable throughout; accepted on the 4th cycle.
REQ-032 Response inst 0x00500093 arrives while stall=1 for 2 cycles -> IF/ID unchanged and no new request; after stall drops, IF_ID_inst=0x00500093, IF_ID_rd=1, IF_ID_opcode=0x13.
REQ-033 pc_sel=1 with pc_imm=0x103 while in WAIT -> bubble in IF/ID; the late response is dropped; next request address is 0x100.
REQ-034 pc_sel and stall together with a response -> bubble wins; hold buffer stays empty; pc=pc_imm.
REQ-035 reset asserted in WAIT, response arrives the cycle after reset -> response ignored; first request is to RESET_PC.
